// File: rtl/square_mul_seq_pkg.sv
// Shared types and helpers for the limb-serial multiplier/squarer.
package square_mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Number of MAC cycles for an n-limb operand: the square skips the mirrored half.
  function automatic int unsigned pair_count(input int unsigned n, input logic square);
    if (square) begin
      return (n * (n + 1)) / 2;
    end
    return n * n;
  endfunction

endpackage

// File: rtl/square_mul_seq_limb_mul.sv
// Combinational LIMB x LIMB -> 2*LIMB unsigned multiply, sized for one DSP slice.
module limb_mul
  import square_mul_seq_pkg::*;
#(
  parameter int unsigned LIMB = 32
) (
  input  logic [LIMB-1:0]   x,
  input  logic [LIMB-1:0]   y,
  output logic [2*LIMB-1:0] p_c
);

  localparam int unsigned PW = 2 * LIMB;

  assign p_c = PW'(x) * PW'(y);

endmodule

// File: rtl/square_mul_seq.sv
// Limb-serial unsigned multiplier/squarer: one limb product accumulated per cycle.
module square_mul_seq
  import square_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned LIMB  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done
);

  localparam bit          PARAMS_OK = (LIMB == 0) ? 1'b0 : ((WIDTH % LIMB) == 0);
  localparam int unsigned N         = (LIMB == 0) ? 1 : WIDTH / LIMB;
  localparam int unsigned IDX_W     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ACC_W     = 2 * WIDTH;
  localparam int unsigned SH_W      = $clog2(ACC_W) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (!PARAMS_OK) begin : g_bad_params
    $error("square_mul_seq: WIDTH must be a non-zero multiple of LIMB");
  end

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic                   mode_q, mode_d;
  logic [IDX_W-1:0]       i_q, i_d, j_q, j_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [ACC_W-1:0]       result_q, result_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [LIMB-1:0]        a_limbs [N];
  logic [LIMB-1:0]        b_limbs [N];
  logic [LIMB-1:0]        a_limb_c, b_limb_c;
  logic [2*LIMB-1:0]      prod_c;
  logic [SH_W-1:0]        shamt_c;
  logic                   dbl_c;
  logic                   last_c;
  logic [ACC_W-1:0]       term_c;

  for (genvar k = 0; k < N; k++) begin : g_limbs
    assign a_limbs[k] = a_q[k*LIMB +: LIMB];
    assign b_limbs[k] = b_q[k*LIMB +: LIMB];
  end

  limb_mul #(.LIMB(LIMB)) u_limb_mul (
    .x   (a_limb_c),
    .y   (b_limb_c),
    .p_c (prod_c)
  );

  // Current limb pair, its weight, and whether it is a doubled off-diagonal square term.
  always_comb begin
    a_limb_c = a_limbs[i_q];
    b_limb_c = b_limbs[j_q];
    shamt_c  = SH_W'(LIMB) * (SH_W'(i_q) + SH_W'(j_q));
    dbl_c    = mode_q && (i_q != j_q);
    last_c   = (i_q == LAST_IDX) && (j_q == LAST_IDX);
    term_c   = (ACC_W'(prod_c) << shamt_c) << dbl_c;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    i_d      = i_q;
    j_d      = j_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = mode ? a : b;
          mode_d  = mode;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + term_c;
        if (last_c) begin
          state_d = ST_FINISH;
        end else if (j_q == LAST_IDX) begin
          // Square mode walks only the upper triangle, so j restarts on the diagonal.
          i_d = i_q + IDX_W'(1);
          j_d = mode_q ? (i_q + IDX_W'(1)) : '0;
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      ST_FINISH: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      i_q      <= i_d;
      j_q      <= j_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_square_mul_seq.sv
// Directed and randomized checks of square_mul_seq against an exact-arithmetic product model.
module tb_square_mul_seq;

  localparam int unsigned WIDTH = 128;
  localparam int unsigned LIMB  = 32;
  localparam int unsigned N     = WIDTH / LIMB;
  localparam int unsigned P_MUL = N * N;
  localparam int unsigned P_SQR = N * (N + 1) / 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic [2*WIDTH-1:0] result;
  logic               done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  square_mul_seq #(.WIDTH(WIDTH), .LIMB(LIMB)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .result (result),
    .done   (done)
  );

  task automatic check(input string tag, input logic [2*WIDTH-1:0] obs, input logic [2*WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] model(input logic m, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] xx, yy;
    xx = 256'(x);
    yy = m ? 256'(x) : 256'(y);
    return xx * yy;
  endfunction

  function automatic logic [WIDTH-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, check busy every cycle, then latency, result and the done pulse.
  task automatic run_op(input logic m, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input string tag, input bit disturb);
    logic [2*WIDTH-1:0] exp;
    int p;
    int cyc;
    exp   = model(m, x, y);
    p     = m ? P_SQR : P_MUL;
    mode  = m;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 40) begin
      check({tag, " busy"}, 256'(busy), 256'(1));
      if (disturb && cyc == 5) begin
        start = 1'b1;
        mode  = ~m;
        a     = rand128();
        b     = rand128();
      end else if (disturb && cyc == 6) begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, 256'(cyc), 256'(p + 1));
    check({tag, " result"}, result, exp);
    check({tag, " busy low at done"}, 256'(busy), 256'(0));
    tick();
    check({tag, " done one cycle"}, 256'(done), 256'(0));
  endtask

  initial begin
    logic [WIDTH-1:0]   x;
    logic [2*WIDTH-1:0] expq[$];
    int extra;
    int t;
    int last_t;
    int waited;

    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("reset busy", 256'(busy), 256'(0));
    check("reset done", 256'(done), 256'(0));
    check("reset result", result, 256'(0));
    rst = 1'b0;
    tick();

    run_op(1'b1, 128'd3, rand128(), "square 3", 1'b0);
    run_op(1'b0, 128'd3, 128'd5, "mul 3x5", 1'b0);
    run_op(1'b0, {WIDTH{1'b1}}, {WIDTH{1'b1}}, "mul max", 1'b0);
    x = 128'h123456789ABCDEF0123456789ABCDEF0;
    run_op(1'b1, x, 128'd0, "square wide", 1'b0);
    run_op(1'b0, x, x, "mul wide b=a", 1'b0);
    run_op(1'b1, {WIDTH{1'b1}}, 128'd0, "square max", 1'b0);

    for (int k = 0; k < 8; k++) begin
      run_op(1'($urandom_range(0, 1)), rand128(), rand128(), "random", 1'b0);
    end

    // A second start mid-operation must not disturb the latched operands or add a done.
    run_op(1'b0, rand128(), rand128(), "repulse", 1'b1);
    extra = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) extra++;
    end
    check("repulse single done", 256'(extra), 256'(0));

    // Abort a multiply with reset after edge 6.
    mode  = 1'b0;
    a     = rand128();
    b     = rand128();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check("abort busy", 256'(busy), 256'(0));
    check("abort result", result, 256'(0));
    check("abort done", 256'(done), 256'(0));
    tick();
    tick();
    rst = 1'b0;
    extra = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) extra++;
    end
    check("abort no done", 256'(extra), 256'(0));
    check("abort result held", result, 256'(0));
    run_op(1'b1, 128'd7, rand128(), "post-reset square 7", 1'b0);

    // Back-to-back squares with start held high.
    mode  = 1'b1;
    a     = rand128();
    b     = rand128();
    expq.push_back(model(1'b1, a, b));
    start = 1'b1;
    t      = 0;
    last_t = 0;
    tick();
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      do begin
        tick();
        t++;
        waited++;
      end while (done !== 1'b1 && waited < 40);
      check("b2b done seen", 256'(done), 256'(1));
      check("b2b result", result, expq[k]);
      if (k == 0) check("b2b first latency", 256'(t), 256'(P_SQR + 1));
      else        check("b2b spacing", 256'(t - last_t), 256'(P_SQR + 2));
      last_t = t;
      if (k < 3) begin
        a = rand128();
        expq.push_back(model(1'b1, a, b));
      end else begin
        start = 1'b0;
      end
    end
    tick();
    check("b2b idle after stop", 256'(busy), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/square_mul_seq.md
SQUARE_MUL_SEQ -- requirements
Module: square_mul_seq

Interface
REQ-001: Parameter WIDTH, default 128, operand width in bits.
REQ-002: Parameter LIMB, default 32, limb width in bits, one DSP-sized multiply per cycle.
REQ-003: Derived constant N = WIDTH/LIMB, the number of limbs per operand.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: rst  input  1  reset, asynchronous and active-high.
REQ-006: start  input  1  request; sampled only in IDLE.
REQ-007: mode  input  1  operation select: 1 = square a*a (b ignored), 0 = multiply a*b.
REQ-008: a  input  WIDTH  operand A, unsigned.
REQ-009: b  input  WIDTH  operand B, unsigned.
REQ-010: busy  output  1  high while an operation is in progress (MAC or FINISH).
REQ-011: result  output  2*WIDTH  product, held until the next completion.
REQ-012: done  output  1  one-cycle pulse when result is updated.

Function
REQ-013: FSM states SHALL be IDLE, MAC and FINISH.
REQ-014: IDLE with start=1: latch a, b and mode (b_reg = a when mode=1), clear the 2*WIDTH accumulator, zero the limb indices i, j, and go to MAC.
REQ-015: MAC, multiply mode: one limb pair per cycle, row-major (i outer, j inner, 0..N-1 each), P = N*N cycles; acc += (a_i*b_j) << (LIMB*(i+j)).
REQ-016: MAC, square mode: pairs with j>=i only, row-major, j restarting at i; P = N(N+1)/2 cycles; diagonal terms added once, off-diagonal terms shifted left one extra bit (doubled).
REQ-017: On the last pair, MAC SHALL go to FINISH.
REQ-018: FINISH: result <= acc, done <= 1 for exactly one cycle, then return to IDLE.
REQ-019: Latency: with start sampled at edge 0, done and result SHALL be valid after edge P+1 (N=4: 17 cycles multiply, 11 cycles square).
REQ-020: busy SHALL be 1 after edges 0..P and 0 in the cycle done is high.
REQ-021: start while busy=1 SHALL be ignored; no queuing; latched operands are unaffected by input changes.
REQ-022: start in the cycle done is high (state IDLE) SHALL be accepted; back-to-back throughput is one operation per P+2 cycles.
REQ-023: Arithmetic SHALL be unsigned with a 2*WIDTH accumulator; no truncation; the result equals the exact product.
REQ-024: N=1 SHALL be legal, with P=1 in both modes.
REQ-025: Elaboration SHALL fail if WIDTH mod LIMB != 0 or LIMB < 1.

Reset
REQ-026: rst=1 SHALL force IDLE and set result=0, done=0, busy=0, acc=0, indices=0 and operand registers to 0, independent of clk.
REQ-027: rst asserted mid-operation SHALL abort it; no done is produced for the aborted operation.
REQ-028: The first start after rst deasserts SHALL be handled normally.

Structure
REQ-029: A shared package SHALL hold the FSM state enum and a function computing P(N, mode).
REQ-030: One sub-module, limb_mul, SHALL perform the combinational LIMB x LIMB -> 2*LIMB unsigned multiply mapped to a DSP.
REQ-031: Index counters, shifting and accumulation SHALL reside in square_mul_seq.

Verification
REQ-032: Square 3 (WIDTH=128, LIMB=32): mode=1, a=3 -> result=9, done pulses exactly 11 cycles after start, busy high for 11 cycles.
REQ-033: Multiply: mode=0, a=3, b=5 -> result=15 after 17 cycles; a=b=2^128-1 -> result=2^256-2^129+1.
REQ-034: Square wide operand: a=128'h123456789ABCDEF0123456789ABCDEF0 -> result equals the golden model a*a; repeat in multiply mode with b=a, giving the same result.
REQ-035: start re-pulsed at cycle 5 of an operation with different a -> ignored; the first result is correct; only one done pulse.
REQ-036: rst asserted at cycle 6 of a multiply -> busy=0, result=0, no done; the next start, a=7, mode=1 -> result=49.
REQ-037: Back-to-back: start held high -> consecutive done pulses 12 cycles apart in square mode, each result correct.
